// File: rtl/rv_pkg.sv
// Shared types and constants for the rvtu divide client.
// Contents: divide function select encoding, client FSM states,
// registered operand payload, and the signed-overflow dividend constant.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    // bit0 = unsigned, bit1 = remainder
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_fsel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } div_client_state_t;

    // Operands held toward the divider arbiter port
    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        div_fsel_t       fsel;
    } div_op_t;

endpackage

// File: rtl/rvtu_div_special.sv
// Combinational detection of RISC-V divide special cases and their results.
// Ports:
//   src1_i, src2_i : dividend, divisor
//   fsel_i         : bit0 = unsigned, bit1 = remainder
//   special_c      : divide-by-zero or signed overflow; result_c is final
//   result_c       : architectural result for the special case (0 otherwise)
module rvtu_div_special
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [1:0]      fsel_i,
    output logic            special_c,
    output logic [XLEN-1:0] result_c
);

    logic div_by_zero;
    logic overflow;

    assign div_by_zero = (src2_i == '0);
    // Only signed ops overflow: most-negative / -1
    assign overflow    = ~fsel_i[0] & (src1_i == DIV_OVF_DIVIDEND) & (src2_i == '1);

    always_comb begin
        special_c = div_by_zero | overflow;
        result_c  = '0;
        if (div_by_zero) begin
            result_c = fsel_i[1] ? src1_i : '1;
        end else if (overflow) begin
            result_c = fsel_i[1] ? '0 : DIV_OVF_DIVIDEND;
        end
    end

endmodule

// File: rtl/rvtu_div_client.sv
// Requester endpoint for one port of the shared arbitrated divider.
// Accepts a divide op from issue, resolves special cases locally, otherwise
// holds a request on the divider port until resp, and presents the result
// to writeback through a one-entry valid/ready register. Kill drains any
// in-flight request without breaking the arbiter handshake.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   iss_valid/ready/src1/src2/fsel/tag : issue handshake and operands
//   kill                           : pipeline flush
//   div_req/src1/src2/fsel         : divider arbiter request (registered)
//   div_resp, div_out              : divider completion pulse and result
//   wb_valid/ready/data/tag        : writeback handshake and result
module rvtu_div_client
    import rv_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [XLEN-1:0]  iss_src1,
    input  logic [XLEN-1:0]  iss_src2,
    input  logic [1:0]       iss_fsel,
    input  logic [TAG_W-1:0] iss_tag,
    input  logic             kill,
    output logic             div_req,
    output logic [XLEN-1:0]  div_src1,
    output logic [XLEN-1:0]  div_src2,
    output logic [1:0]       div_fsel,
    input  logic             div_resp,
    input  logic [XLEN-1:0]  div_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [XLEN-1:0]  wb_data,
    output logic [TAG_W-1:0] wb_tag
);

    div_client_state_t state_q, state_d;
    div_op_t           op_q, op_d;
    logic              div_req_q, div_req_d;
    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;

    logic              accept;
    logic              special;
    logic [XLEN-1:0]   special_result;

    // Special cases are judged on the incoming operands so they finish in one cycle
    rvtu_div_special u_special (
        .src1_i    (iss_src1),
        .src2_i    (iss_src2),
        .fsel_i    (iss_fsel),
        .special_c (special),
        .result_c  (special_result)
    );

    assign iss_ready = ~kill & ((state_q == IDLE) | ((state_q == DONE) & wb_ready));
    assign accept    = iss_valid & iss_ready;

    // Next-state and output-register logic
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        div_req_d  = div_req_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_tag_d   = wb_tag_q;

        unique case (state_q)
            IDLE: begin
            end
            WAIT: begin
                if (div_resp) begin
                    div_req_d = 1'b0;
                    if (kill) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = div_out;
                    end
                end else if (kill) begin
                    // Request must stay up until the arbiter answers
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (div_resp) begin
                    div_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            DONE: begin
                if (kill) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end else if (wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept only happens from IDLE or a consuming DONE, so it overrides the above
        if (accept) begin
            op_d.src1 = iss_src1;
            op_d.src2 = iss_src2;
            op_d.fsel = div_fsel_t'(iss_fsel);
            wb_tag_d  = iss_tag;
            if (special) begin
                state_d    = DONE;
                div_req_d  = 1'b0;
                wb_valid_d = 1'b1;
                wb_data_d  = special_result;
            end else begin
                state_d    = WAIT;
                div_req_d  = 1'b1;
                wb_valid_d = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            div_req_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            div_req_q  <= div_req_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_tag_q   <= wb_tag_d;
        end
    end

    assign div_req  = div_req_q;
    assign div_src1 = op_q.src1;
    assign div_src2 = op_q.src2;
    assign div_fsel = op_q.fsel;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_tag   = wb_tag_q;

    // A response is only legal while a request is outstanding
    resp_while_requesting_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        div_resp |-> (state_q == WAIT || state_q == DRAIN)
    );

endmodule

// File: tb/tb_rvtu_div_client.sv
// Self-checking bench for rvtu_div_client: directed cases plus random traffic,
// a behavioural arbiter, and a scoreboard monitor on the writeback side.
module tb_rvtu_div_client;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             iss_valid;
    logic             iss_ready;
    logic [31:0]      iss_src1;
    logic [31:0]      iss_src2;
    logic [1:0]       iss_fsel;
    logic [TAG_W-1:0] iss_tag;
    logic             kill;
    logic             div_req;
    logic [31:0]      div_src1;
    logic [31:0]      div_src2;
    logic [1:0]       div_fsel;
    logic             div_resp;
    logic [31:0]      div_out;
    logic             wb_valid;
    logic             wb_ready;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;

    rvtu_div_client #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_src1  (iss_src1),
        .iss_src2  (iss_src2),
        .iss_fsel  (iss_fsel),
        .iss_tag   (iss_tag),
        .kill      (kill),
        .div_req   (div_req),
        .div_src1  (div_src1),
        .div_src2  (div_src2),
        .div_fsel  (div_fsel),
        .div_resp  (div_resp),
        .div_out   (div_out),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_tag    (wb_tag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // RISC-V M-extension divide semantics, straight from the ISA rules
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] f);
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return f[1] ? 32'd0 : 32'h8000_0000;
            return f[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit ref_fast(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
        return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // ---------------- scoreboard / model ----------------
    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    bit   m_avail = 1'b0;   // held op's result is presentable
    bit   m_drain = 1'b0;   // killed request still awaiting the arbiter

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_avail = 1'b0;
            m_drain = 1'b0;
        end else begin
            bit   held, exp_valid, exp_req, exp_rdy;
            exp_t e;
            held      = (q.size() != 0);
            exp_valid = held && m_avail;
            exp_req   = (held && !m_avail) || m_drain;
            exp_rdy   = !kill && ((!held && !m_drain) || (exp_valid && wb_ready));

            check("wb_valid", 32'(wb_valid), 32'(exp_valid));
            check("div_req", 32'(div_req), 32'(exp_req));
            check("iss_ready", 32'(iss_ready), 32'(exp_rdy));
            if (exp_valid) begin
                check("wb_data_hold", wb_data, q[0].data);
                check("wb_tag_hold", 32'(wb_tag), 32'(q[0].tag));
            end

            if (m_drain && div_resp) m_drain = 1'b0;

            if (exp_valid && wb_ready && !kill) begin
                e = q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_tag", 32'(wb_tag), 32'(e.tag));
                m_avail = 1'b0;
            end else if (kill && held) begin
                if (!m_avail && !div_resp) m_drain = 1'b1;
                void'(q.pop_front());
                m_avail = 1'b0;
            end else if (held && !m_avail && div_resp) begin
                m_avail = 1'b1;
            end

            if (iss_valid && exp_rdy) begin
                e.data = ref_result(iss_src1, iss_src2, iss_fsel);
                e.tag  = iss_tag;
                q.push_back(e);
                m_avail = ref_fast(iss_src1, iss_src2, iss_fsel);
            end
        end
    end

    // ---------------- arbiter model ----------------
    int lat_force    = 0;
    int last_req_len = 0;

    initial begin
        int          cnt;
        int          lat;
        logic [31:0] s1, s2;
        logic [1:0]  f;
        cnt = 0; lat = 1; s1 = '0; s2 = '0; f = '0;
        div_resp = 1'b0;
        div_out  = '0;
        forever begin
            @(posedge clk);
            #1;
            div_resp = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (div_req) begin
                if (cnt == 0) begin
                    lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 6));
                    s1 = div_src1; s2 = div_src2; f = div_fsel;
                end else begin
                    check("div_src1_stable", div_src1, s1);
                    check("div_src2_stable", div_src2, s2);
                    check("div_fsel_stable", 32'(div_fsel), 32'(f));
                end
                cnt++;
                if (cnt == lat) begin
                    div_resp     = 1'b1;
                    div_out      = ref_result(s1, s2, f);
                    last_req_len = cnt;
                    cnt          = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] f, input logic [TAG_W-1:0] t);
        bit acc;
        acc       = 1'b0;
        iss_valid = 1'b1;
        iss_src1  = a;
        iss_src2  = b;
        iss_fsel  = f;
        iss_tag   = t;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = iss_ready;
            step();
        end
        iss_valid = 1'b0;
        check("issue_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 200 && !idle; n++) begin
            if (q.size() == 0 && !m_drain && !div_req) idle = 1'b1;
            else step();
        end
        check("reach_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_src1 = '0; iss_src2 = '0;
        iss_fsel = '0; iss_tag = '0; kill = 1'b0; wb_ready = 1'b1;

        #12;
        check("rst_div_req", 32'(div_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_tag", 32'(wb_tag), 32'd0);
        check("rst_div_src1", div_src1, 32'd0);
        check("rst_div_src2", div_src2, 32'd0);
        check("rst_div_fsel", 32'(div_fsel), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // DIVU 100/7 with a 6-cycle arbiter
        lat_force = 6;
        issue(32'd100, 32'd7, 2'b01, 5'd3);
        wait_idle();
        check("divu_req_len", 32'(last_req_len), 32'd6);

        // REM -7 / 2
        lat_force = 3;
        issue(32'hFFFF_FFF9, 32'd2, 2'b10, 5'd4);
        wait_idle();

        // Local special cases
        issue(32'd55, 32'd0, 2'b00, 5'd5);
        issue(32'h0000_1234, 32'd0, 2'b11, 5'd6);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 5'd7);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 5'd8);
        wait_idle();

        // Kill two cycles into WAIT: drain
        lat_force = 6;
        issue(32'd1000, 32'd9, 2'b00, 5'd9);
        step(); step();
        kill = 1'b1; step(); kill = 1'b0;
        wait_idle();

        // Kill coincident with resp
        lat_force = 3;
        issue(32'd1000, 32'd9, 2'b01, 5'd10);
        step(); step();
        kill = 1'b1; step(); kill = 1'b0;
        wait_idle();

        // Writeback stall then back-to-back accept
        lat_force = 2;
        wb_ready  = 1'b0;
        issue(32'd81, 32'd9, 2'b01, 5'd11);
        fork
            issue(32'd77, 32'd0, 2'b01, 5'd12);
            begin
                for (int i = 0; i < 5; i++) step();
                wb_ready = 1'b1;
            end
        join
        wait_idle();

        // Asynchronous reset mid-WAIT
        lat_force = 6;
        issue(32'd500, 32'd3, 2'b00, 5'd13);
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_div_req", 32'(div_req), 32'd0);
        check("async_rst_wb_valid", 32'(wb_valid), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Random traffic
        lat_force = 0;
        for (int c = 0; c < 600; c++) begin
            int sel;
            sel       = int'($urandom_range(0, 7));
            iss_valid = $urandom_range(0, 1) == 1;
            iss_fsel  = 2'($urandom_range(0, 3));
            iss_tag   = TAG_W'($urandom);
            iss_src1  = $urandom;
            iss_src2  = (sel < 4) ? 32'($urandom_range(1, 300)) : $urandom;
            if (sel == 0) begin
                iss_src1 = 32'h8000_0000;
                iss_src2 = 32'hFFFF_FFFF;
            end else if (sel == 1) begin
                iss_src2 = 32'd0;
            end
            kill     = $urandom_range(0, 19) == 0;
            wb_ready = $urandom_range(0, 9) < 7;
            step();
        end
        iss_valid = 1'b0;
        kill      = 1'b0;
        wb_ready  = 1'b1;
        wait_idle();
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
